wb_arbiter: RTL and testbench

Writeback arbiter and load scoreboard sitting between the execute/memory stages and the general-purpose register file. It merges single-cycle ALU results and long-latency LSU results onto the register file's single write port, buffering LSU results when the port is taken. It tracks destination registers of in-flight loads and raises a hazard to decode when an instruction would read or overwrite one.

---
 rtl/wb_arbiter_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-file widths, constants and the buffered LSU entry type
package wb_arbiter_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int RegNum     = 32;
  localparam int EntryW     = RegAddrBus + RegBus;

  localparam logic [RegAddrBus-1:0] ZeroReg = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b0;

  typedef struct packed {
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - LSU result FIFO; an empty FIFO forwards a same-cycle push straight to its head
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_write, do_read;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? wdata_i : mem_q[rptr_q];

  // A push popped in the same cycle on an empty FIFO never touches storage.
  assign do_write = push_i && !(empty_o && pop_i);
  assign do_read  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_write) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    if (do_read)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and buffered LSU results onto the register-file write port
// and tracks destinations of in-flight loads for decode hazards.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LSU_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  input  logic        lsu_issue_i,
  input  logic [4:0]  lsu_issue_rd_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  id_raddr1_i,
  input  logic [4:0]  id_raddr2_i,
  input  logic [4:0]  id_rd_i,
  output logic        hazard_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] busy_o
);

  localparam int CNT_W = $clog2(LSU_DEPTH + 1);

  wb_entry_t         push_entry, head_entry;
  logic [EntryW-1:0] head_bits;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              lsu_push, head_valid, alu_win, pop;

  logic              we_q, we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [RegNum-1:0] busy_q, busy_d;

  assign push_entry = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
  assign head_entry = wb_entry_t'(head_bits);

  assign lsu_ready_o = rst_n && !fifo_full;
  assign lsu_push    = lsu_valid_i && lsu_ready_o;
  assign head_valid  = !fifo_empty || lsu_push;
  assign alu_win     = alu_we_i && (alu_waddr_i != ZeroReg);
  assign pop         = !alu_win && head_valid;

  wb_fifo #(
    .DEPTH (LSU_DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (lsu_push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    we_d    = WriteDisable;
    waddr_d = ZeroReg;
    wdata_d = '0;
    busy_d  = busy_q;
    if (alu_win) begin
      we_d    = WriteEnable;
      waddr_d = alu_waddr_i;
      wdata_d = alu_wdata_i;
    end else if (pop) begin
      // An LSU entry for x0 is still consumed so the buffer keeps draining.
      busy_d[head_entry.waddr] = 1'b0;
      if (head_entry.waddr != ZeroReg) begin
        we_d    = WriteEnable;
        waddr_d = head_entry.waddr;
        wdata_d = head_entry.wdata;
      end
    end
    // Applied after the clear so a new load to the same register stays pending.
    if (lsu_issue_i && (lsu_issue_rd_i != ZeroReg)) busy_d[lsu_issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      we_q    <= WriteDisable;
      waddr_q <= ZeroReg;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign hazard_o = busy_q[id_raddr1_i] | busy_q[id_raddr2_i] | busy_q[id_rd_i]
                  | (fifo_count == CNT_W'(LSU_DEPTH));

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk, rst_n;
  logic        alu_we, lsu_issue, lsu_valid, lsu_ready, hazard, we;
  logic [4:0]  alu_waddr, issue_rd, lsu_waddr, rs1, rs2, rd, waddr;
  logic [31:0] alu_wdata, lsu_wdata, wdata, busy;

  wb_arbiter #(.LSU_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_we_i       (alu_we),
    .alu_waddr_i    (alu_waddr),
    .alu_wdata_i    (alu_wdata),
    .lsu_issue_i    (lsu_issue),
    .lsu_issue_rd_i (issue_rd),
    .lsu_valid_i    (lsu_valid),
    .lsu_ready_o    (lsu_ready),
    .lsu_waddr_i    (lsu_waddr),
    .lsu_wdata_i    (lsu_wdata),
    .id_raddr1_i    (rs1),
    .id_raddr2_i    (rs2),
    .id_rd_i        (rd),
    .hazard_o       (hazard),
    .we_o           (we),
    .waddr_o        (waddr),
    .wdata_o        (wdata),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          last_xfer;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
      $error("%s.%s", tag, what);
    end
  endtask

  task automatic idle();
    alu_we = 0; alu_waddr = 0; alu_wdata = 0;
    lsu_issue = 0; issue_rd = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    rs1 = 0; rs2 = 0; rd = 0;
  endtask

  // Checks combinational outputs mid-cycle, advances the model, checks registered outputs after the edge.
  task automatic cycle(string tag);
    bit   full;
    ent_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk(tag, "ready_in_reset", {31'b0, lsu_ready}, 32'd0);
      q.delete();
      m_busy = 0; m_we = 0; last_xfer = 0;
    end else begin
      full = (q.size() == DEPTH);
      chk(tag, "hazard", {31'b0, hazard},
          {31'b0, m_busy[rs1] | m_busy[rs2] | m_busy[rd] | full});
      chk(tag, "ready", {31'b0, lsu_ready}, {31'b0, !full});
      last_xfer = lsu_valid && !full;
      if (last_xfer) q.push_back('{a: lsu_waddr, d: lsu_wdata});
      m_we = 0;
      if (alu_we && alu_waddr != 0) begin
        m_we = 1; m_waddr = alu_waddr; m_wdata = alu_wdata;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_busy[e.a] = 1'b0;
        if (e.a != 0) begin
          m_we = 1; m_waddr = e.a; m_wdata = e.d;
        end
      end
      if (lsu_issue && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk(tag, "we", {31'b0, we}, {31'b0, m_we});
    chk(tag, "busy", busy, m_busy);
    if (m_we) begin
      chk(tag, "waddr", {27'b0, waddr}, {27'b0, m_waddr});
      chk(tag, "wdata", wdata, m_wdata);
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    m_busy = 0; m_we = 0; last_xfer = 0;
    @(posedge clk); #1;
    cycle("reset");
    chk("reset", "waddr", {27'b0, waddr}, 32'd0);
    chk("reset", "wdata", wdata, 32'd0);
    rst_n = 1;
    cycle("post_reset");

    // ALU write x5, then ALU write to x0 dropped
    alu_we = 1; alu_waddr = 5; alu_wdata = 32'h1234;
    cycle("alu_x5");
    chk("alu_x5", "waddr_const", {27'b0, waddr}, 32'd5);
    alu_waddr = 0; alu_wdata = 32'hFFFF;
    cycle("alu_x0");
    chk("alu_x0", "we_const", {31'b0, we}, 32'd0);
    idle();

    // Load to x7: busy, RAW hazard, then writeback clears it
    lsu_issue = 1; issue_rd = 7;
    cycle("issue_x7");
    idle(); rs1 = 7;
    cycle("raw_x7");
    lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'hDEAD;
    cycle("ret_x7");
    chk("ret_x7", "wdata_const", wdata, 32'h0000DEAD);
    lsu_valid = 0;
    cycle("after_x7");

    // ALU and LSU collide
    idle();
    alu_we = 1; alu_waddr = 3; alu_wdata = 32'h11;
    lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'h22;
    cycle("collide");
    idle();
    cycle("collide_lsu");
    cycle("collide_drain");

    // Fill the buffer behind continuous ALU writes, then one bubble
    alu_we = 1; alu_waddr = 1; alu_wdata = 32'hA1;
    lsu_valid = 1; lsu_waddr = 10; lsu_wdata = 32'hB10;
    cycle("fill0");
    alu_waddr = 2; alu_wdata = 32'hA2; lsu_waddr = 11; lsu_wdata = 32'hB11;
    cycle("fill1");
    alu_waddr = 3; alu_wdata = 32'hA3; lsu_waddr = 12; lsu_wdata = 32'hB12;
    cycle("full_stall");
    chk("full_stall", "hazard_const", {31'b0, hazard}, 32'd1);
    alu_we = 0;
    cycle("bubble");
    chk("bubble", "ready_const", {31'b0, lsu_ready}, 32'd1);
    cycle("bubble_push");
    idle();
    cycle("drain0");
    cycle("drain1");

    // Re-issue to x4 in the cycle the older x4 load pops
    lsu_issue = 1; issue_rd = 4;
    cycle("issue_x4");
    lsu_valid = 1; lsu_waddr = 4; lsu_wdata = 32'h44;
    cycle("x4_set_wins");
    chk("x4_set_wins", "busy4_const", {31'b0, busy[4]}, 32'd1);
    lsu_issue = 0; lsu_wdata = 32'h45;
    cycle("x4_second");
    idle();

    // Reset mid-operation with a full buffer and x4/x7 pending
    alu_we = 1; alu_waddr = 1; alu_wdata = 32'hC1;
    lsu_issue = 1; issue_rd = 4;
    lsu_valid = 1; lsu_waddr = 20; lsu_wdata = 32'hD20;
    cycle("pre_rst0");
    issue_rd = 7; alu_waddr = 2; lsu_waddr = 21; lsu_wdata = 32'hD21;
    cycle("pre_rst1");
    chk("pre_rst1", "busy_const", busy, 32'h0000_0090);
    rst_n = 0; lsu_issue = 0; lsu_valid = 0; alu_waddr = 3;
    cycle("mid_reset");
    rst_n = 1; idle();
    cycle("rst_release0");
    cycle("rst_release1");
    cycle("rst_release2");

    // Randomized traffic; a presented LSU result is held until accepted
    for (int i = 0; i < 600; i++) begin
      alu_we    = ($urandom % 10) < 6;
      alu_waddr = 5'($urandom);
      alu_wdata = $urandom;
      lsu_issue = ($urandom % 10) < 3;
      issue_rd  = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      if (!lsu_valid || last_xfer) begin
        lsu_valid = ($urandom % 2) == 1;
        lsu_waddr = 5'($urandom);
        lsu_wdata = $urandom;
      end
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
